hqm_rop_flr_prep_ctl: RTL and testbench

// - Drives flr_prep into the reorder-pipe interface protection cells during a function-level reset (FLR).
// - Consumes the ROP status signals those cells gate: rop_unit_idle, rop_unit_pipeidle and rop_reset_done.
// - Sequence: block new HCWs -> wait for the ROP to drain -> assert flr_prep -> wait for the ROP reset to complete -> report done.
// - Sits in the system/FLR control path, between the FLR requester and the ROP boundary.

---
 rtl/hqm_rop_flr_prep_ctl_if.sv | 24 ++
 rtl/hqm_rop_flr_prep_ctl.sv | 148 ++++++++++++++
 tb/tb_hqm_rop_flr_prep_ctl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hqm_rop_flr_prep_ctl_if.sv
// Interface bundling the FLR request, the ROP status inputs and the FLR
// preparation outputs of hqm_rop_flr_prep_ctl.
// master: the FLR requester / ROP side. slave: the controller itself.
interface hqm_rop_flr_prep_ctl_if;
  logic       flr_req;
  logic       rop_unit_idle;
  logic       rop_unit_pipeidle;
  logic       rop_reset_done;
  logic       flr_prep;
  logic       hcw_block;
  logic       flr_done;
  logic       flr_timeout;
  logic [1:0] flr_state;

  modport master (
    output flr_req, rop_unit_idle, rop_unit_pipeidle, rop_reset_done,
    input  flr_prep, hcw_block, flr_done, flr_timeout, flr_state
  );

  modport slave (
    input  flr_req, rop_unit_idle, rop_unit_pipeidle, rop_reset_done,
    output flr_prep, hcw_block, flr_done, flr_timeout, flr_state
  );
endinterface

// File: rtl/hqm_rop_flr_prep_ctl.sv
// FLR preparation controller for the reorder pipe (ROP).
// Sequence: block new HCWs, wait for the ROP to drain, assert flr_prep
// toward the protection cells, wait for the ROP reset to complete, report
// done. All outputs are registered.
// Optional watchdog: define HQM_ROP_FLR_TIMEOUT_EN to force progress out of
// BLOCK and PREP after TIMEOUT_CYC cycles (pulsing flr_timeout). The
// TIMEOUT_CYC parameter only exists when the watchdog is compiled in.
module hqm_rop_flr_prep_ctl #(
  parameter int unsigned IDLE_STABLE_CYC = 8
`ifdef HQM_ROP_FLR_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC     = 1024
`endif
) (
  input  logic                  hqm_gated_clk,
  input  logic                  hqm_gated_rst_n,
  hqm_rop_flr_prep_ctl_if.slave flr_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLOCK = 2'd1,
    ST_PREP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned     STAB_W   = $clog2(IDLE_STABLE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(IDLE_STABLE_CYC);

  state_t              state_q, state_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic                seen_low_q, seen_low_d;
  logic                timeout_d;
  logic                wd_hit;
  logic                both_idle;
  logic                prep_q, block_q, done_q;

  assign both_idle = flr_if.rop_unit_idle & flr_if.rop_unit_pipeidle;

`ifdef HQM_ROP_FLR_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q;

  assign wd_hit = (wd_cnt_q == WD_LAST);

  // Watchdog runs only while waiting in BLOCK or PREP; restarts per state.
  always_comb begin
    wd_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_BLOCK) || (state_q == ST_PREP)))
      wd_cnt_d = (wd_cnt_q == 16'hffff) ? wd_cnt_q : wd_cnt_q + 16'd1;
  end

  // Watchdog counter and timeout pulse registers.
  always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
    if (!hqm_gated_rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flr_if.flr_timeout = timeout_q;
`else
  // Without the watchdog BLOCK and PREP wait indefinitely.
  assign wd_hit             = 1'b0;
  assign flr_if.flr_timeout = 1'b0;
`endif

  // Next-state decode; the forced (watchdog) exits rank below normal exits.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flr_if.flr_req) state_d = ST_BLOCK;
      end
      ST_BLOCK: begin
        if (!flr_if.flr_req) begin
          state_d = ST_IDLE;
        end else if (stab_cnt_q == STAB_MAX) begin
          state_d = ST_PREP;
        end else if (wd_hit) begin
          state_d   = ST_PREP;
          timeout_d = 1'b1;
        end
      end
      ST_PREP: begin
        // Committed: flr_req is deliberately not looked at here.
        if (flr_if.rop_reset_done && seen_low_q) begin
          state_d = ST_DONE;
        end else if (wd_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!flr_if.flr_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle-stability counter and reset_done low-seen flag; both restart on
  // every state change.
  always_comb begin
    stab_cnt_d = '0;
    seen_low_d = 1'b0;
    if (state_d == state_q) begin
      if ((state_q == ST_BLOCK) && both_idle)
        stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1;
      if (state_q == ST_PREP)
        seen_low_d = seen_low_q | ~flr_if.rop_reset_done;
    end
  end

  // State, tracking registers and registered outputs.
  always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
    if (!hqm_gated_rst_n) begin
      state_q    <= ST_IDLE;
      stab_cnt_q <= '0;
      seen_low_q <= 1'b0;
      prep_q     <= 1'b0;
      block_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      seen_low_q <= seen_low_d;
      prep_q     <= (state_d == ST_PREP);
      block_q    <= (state_d == ST_BLOCK) || (state_d == ST_PREP);
      done_q     <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign flr_if.flr_prep  = prep_q;
  assign flr_if.hcw_block = block_q;
  assign flr_if.flr_done  = done_q;
  assign flr_if.flr_state = state_q;

endmodule

// File: tb/tb_hqm_rop_flr_prep_ctl.sv
// Self-checking bench for hqm_rop_flr_prep_ctl: directed scenarios followed
// by randomized traffic, every cycle compared against a phase/time model.
module tb_hqm_rop_flr_prep_ctl;

  localparam int STAB = 8;
  localparam int TOUT = 16;
`ifdef HQM_ROP_FLR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hqm_rop_flr_prep_ctl_if bus ();

`ifdef HQM_ROP_FLR_TIMEOUT_EN
  hqm_rop_flr_prep_ctl #(.IDLE_STABLE_CYC(STAB), .TIMEOUT_CYC(TOUT)) dut (
`else
  hqm_rop_flr_prep_ctl #(.IDLE_STABLE_CYC(STAB)) dut (
`endif
    .hqm_gated_clk   (clk),
    .hqm_gated_rst_n (rst_n),
    .flr_if          (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase number plus "time spent in this phase" counters.
  int m_phase, m_run, m_wait;
  bit m_seen, m_prep, m_block, m_done, m_to;

  function automatic void model_reset();
    m_phase = 0; m_run = 0; m_wait = 0;
    m_seen = 0; m_prep = 0; m_block = 0; m_done = 0; m_to = 0;
  endfunction

  function automatic void model_edge(bit req, bit idle, bit pipe, bit rd);
    int nxt = m_phase;
    bit to  = 1'b0;
    bit wd  = TO_EN && (m_wait == TOUT - 1);
    case (m_phase)
      0: if (req) nxt = 1;
      1: if (!req) nxt = 0;
         else if (m_run >= STAB) nxt = 2;
         else if (wd) begin nxt = 2; to = 1'b1; end
      2: if (rd && m_seen) nxt = 3;
         else if (wd) begin nxt = 3; to = 1'b1; end
      default: if (!req) nxt = 0;
    endcase
    m_done  = (nxt == 3) && (m_phase != 3);
    m_prep  = (nxt == 2);
    m_block = (nxt == 1) || (nxt == 2);
    m_to    = to;
    if (nxt != m_phase) begin
      m_run = 0; m_seen = 0; m_wait = 0;
    end else begin
      m_run  = (idle && pipe) ? m_run + 1 : 0;
      m_seen = m_seen || !rd;
      m_wait = m_wait + 1;
    end
    m_phase = nxt;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".state"},   16'(bus.flr_state),   16'(m_phase));
    check({tag, ".prep"},    16'(bus.flr_prep),    16'(m_prep));
    check({tag, ".block"},   16'(bus.hcw_block),   16'(m_block));
    check({tag, ".done"},    16'(bus.flr_done),    16'(m_done));
    check({tag, ".timeout"}, 16'(bus.flr_timeout), 16'(m_to));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge(bus.flr_req, bus.rop_unit_idle, bus.rop_unit_pipeidle, bus.rop_reset_done);
    else       model_reset();
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    bit saw;
    bus.flr_req = 1'b0; bus.rop_unit_idle = 1'b1;
    bus.rop_unit_pipeidle = 1'b1; bus.rop_reset_done = 1'b1;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic flow.
    bus.flr_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("basic");
      if (i == 1)  check("basic_block_at1", 16'(bus.hcw_block), 16'd1);
      if (i == 9)  check("basic_prep_at9",  16'(bus.flr_prep),  16'd0);
      if (i == 10) check("basic_prep_at10", 16'(bus.flr_prep),  16'd1);
    end
    bus.rop_reset_done = 1'b0;
    repeat (5) step("basic_rd_low");
    bus.rop_reset_done = 1'b1;
    step("basic_rd_rise");
    check("basic_done_pulse", 16'(bus.flr_done), 16'd1);
    check("basic_state_done", 16'(bus.flr_state), 16'd3);
    step("basic_hold");
    check("basic_done_single", 16'(bus.flr_done), 16'd0);
    bus.flr_req = 1'b0;
    step("basic_release");
    check("basic_back_idle", 16'(bus.flr_state), 16'd0);

    // Idle glitch after 6 stable cycles.
    bus.flr_req = 1'b1;
    step("glitch_enter");
    repeat (6) step("glitch_stable");
    bus.rop_unit_pipeidle = 1'b0;
    step("glitch_drop");
    bus.rop_unit_pipeidle = 1'b1;
    cnt = 0;
    while (!bus.flr_prep && cnt < 30) begin
      step("glitch_wait");
      cnt++;
    end
    check("glitch_clean_cycles", 16'(cnt), 16'd9);
    bus.rop_reset_done = 1'b0; step("glitch_rd_low");
    bus.rop_reset_done = 1'b1; step("glitch_rd_rise");
    bus.flr_req = 1'b0;        step("glitch_release");

    // Abort in BLOCK.
    bus.flr_req = 1'b1;
    saw = 1'b0;
    repeat (4) begin step("abort_block"); saw |= bus.flr_prep | bus.flr_done; end
    bus.flr_req = 1'b0;
    step("abort");
    check("abort_state", 16'(bus.flr_state), 16'd0);
    check("abort_block_low", 16'(bus.hcw_block), 16'd0);
    repeat (5) begin step("abort_after"); saw |= bus.flr_prep | bus.flr_done; end
    check("abort_no_prep_done", 16'(saw), 16'd0);

    // Committed: flr_req drop in PREP is ignored.
    bus.flr_req = 1'b1;
    repeat (10) step("commit_enter");
    bus.flr_req = 1'b0;
    repeat (3) step("commit_hold");
    check("commit_still_prep", 16'(bus.flr_state), 16'd2);
    bus.rop_reset_done = 1'b0;
    repeat (2) step("commit_rd_low");
    bus.rop_reset_done = 1'b1;
    step("commit_rd_rise");
    check("commit_done_pulse", 16'(bus.flr_done), 16'd1);
    step("commit_exit");
    check("commit_idle", 16'(bus.flr_state), 16'd0);

    // Asynchronous reset mid-PREP.
    bus.flr_req = 1'b1;
    repeat (10) step("rst_enter");
    check("rst_in_prep", 16'(bus.flr_state), 16'd2);
    #2;
    async_reset("rst_async");
    bus.flr_req = 1'b0;
    step("rst_release");
    check("rst_state_idle", 16'(bus.flr_state), 16'd0);

    // Watchdog: idle held low.
    bus.rop_unit_idle = 1'b0;
    bus.flr_req = 1'b1;
    step("to_enter");
`ifdef HQM_ROP_FLR_TIMEOUT_EN
    cnt = 0;
    while (bus.flr_state == 2'd1 && cnt < 40) begin step("to_block"); cnt++; end
    check("to_block_cycles", 16'(cnt), 16'(TOUT));
    check("to_block_pulse", 16'(bus.flr_timeout), 16'd1);
    cnt = 0;
    while (bus.flr_state == 2'd2 && cnt < 40) begin step("to_prep"); cnt++; end
    check("to_prep_cycles", 16'(cnt), 16'(TOUT));
    check("to_prep_pulse", 16'(bus.flr_timeout), 16'd1);
`else
    repeat (2000) step("to_wait");
    check("to_still_block", 16'(bus.flr_state), 16'd1);
`endif
    bus.flr_req = 1'b0;
    step("to_release");
    bus.rop_unit_idle = 1'b1;
    step("to_idle");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) bus.flr_req = ~bus.flr_req;
      bus.rop_unit_idle     = ($urandom_range(9) != 0);
      bus.rop_unit_pipeidle = ($urandom_range(11) != 0);
      if ($urandom_range(5) == 0) bus.rop_reset_done = ~bus.rop_reset_done;
      if ($urandom_range(499) == 0) async_reset("rand_rst");
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
